// File: rtl/hci_ecc_scrubber_pkg.sv
// Shared types and helpers for the TCDM ECC scrubber and its Hsiao codec.
package hci_package;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        CHECK = 2'd2,
        WRITE = 2'd3
    } scrub_state_e;

    // Number of Hsiao check bits needed to protect dw data bits (SEC-DED).
    function automatic int unsigned HSIAO_EW(input int unsigned dw);
        return $clog2(dw) + 2;
    endfunction

    // Parity-check column for data bit idx: the idx-th odd-weight (>=3) value
    // of ew bits, ordered by weight first and numeric value second.
    function automatic logic [31:0] hsiao_col(input int unsigned ew, input int unsigned idx);
        int unsigned found;
        logic [31:0] col;
        found = 0;
        col   = '0;
        for (int unsigned w = 3; w <= ew; w += 2) begin
            for (int unsigned v = 1; v < (32'd1 << ew); v++) begin
                if ($countones(v) == w) begin
                    if (found == idx) col = v;
                    found++;
                end
            end
        end
        return col;
    endfunction

endpackage

// File: rtl/hci_ecc_scrubber_hsiao.sv
// Hsiao SEC-DED encoder and decoder; codewords are laid out as {ecc, data}.
module hsiao_ecc_enc
    import hci_package::*;
#(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned ProtWidth = 7
) (
    input  logic [DataWidth-1:0]           data,
    output logic [ProtWidth+DataWidth-1:0] code
);

    logic [ProtWidth-1:0] contrib [DataWidth];
    logic [ProtWidth-1:0] ecc;

    for (genvar i = 0; i < DataWidth; i++) begin : g_col
        localparam logic [31:0] ColFull = hsiao_col(ProtWidth, i);
        assign contrib[i] = data[i] ? ColFull[ProtWidth-1:0] : '0;
    end

    // Each check bit is the parity of the data bits whose column selects it.
    always_comb begin
        ecc = '0;
        for (int i = 0; i < int'(DataWidth); i++) begin
            ecc = ecc ^ contrib[i];
        end
    end

    assign code = {ecc, data};

endmodule

module hsiao_ecc_dec
    import hci_package::*;
#(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned ProtWidth = 7
) (
    input  logic [ProtWidth+DataWidth-1:0] code,
    output logic [DataWidth-1:0]           data,
    output logic [1:0]                     err
);

    logic [ProtWidth+DataWidth-1:0] recoded;
    logic [ProtWidth-1:0]           syndrome;
    logic [DataWidth-1:0]           match;

    hsiao_ecc_enc #(
        .DataWidth (DataWidth),
        .ProtWidth (ProtWidth)
    ) i_reenc (
        .data (code[DataWidth-1:0]),
        .code (recoded)
    );

    assign syndrome = recoded[ProtWidth+DataWidth-1:DataWidth] ^ code[ProtWidth+DataWidth-1:DataWidth];

    for (genvar i = 0; i < DataWidth; i++) begin : g_match
        localparam logic [31:0] ColFull = hsiao_col(ProtWidth, i);
        assign match[i] = (syndrome == ColFull[ProtWidth-1:0]);
    end

    // A data-column syndrome flips exactly that data bit; check-bit errors leave data alone.
    assign data = code[DataWidth-1:0] ^ match;

    // Odd syndromes that hit a column are single errors; even ones are double errors,
    // odd ones hitting nothing are reported as uncorrectable multi-bit errors.
    always_comb begin
        err = 2'b00;
        if (syndrome != '0) begin
            if (^syndrome) begin
                err = ((|match) || $onehot(syndrome)) ? 2'b01 : 2'b11;
            end else begin
                err = 2'b10;
            end
        end
    end

endmodule

// File: rtl/hci_ecc_scrubber.sv
// Background scrubber for one Hsiao-protected TCDM bank: walks the address
// space, writes back single-bit corrections and records uncorrectable errors.
// Bank handshake: scrub_req_o is held with stable address/data until a cycle
// with scrub_gnt_i high; that cycle completes the access. Read data is valid
// on scrub_rdata_i in the cycle after the read grant.
module hci_ecc_scrubber
    import hci_package::*;
#(
    parameter int unsigned DW       = 32,
    parameter int unsigned EW       = HSIAO_EW(DW),
    parameter int unsigned NumWords = 1024,
    parameter int unsigned AW       = $clog2(NumWords),
    parameter int unsigned CntW     = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 scrub_enable_i,
    input  logic [31:0]          scrub_interval_i,
    input  logic                 core_req_i,
    input  logic                 core_wen_i,
    input  logic [AW-1:0]        core_add_i,
    output logic                 scrub_req_o,
    input  logic                 scrub_gnt_i,
    output logic                 scrub_wen_o,
    output logic [AW-1:0]        scrub_add_o,
    output logic [DW+EW-1:0]     scrub_wdata_o,
    input  logic [DW+EW-1:0]     scrub_rdata_i,
    input  logic                 cnt_clear_i,
    output logic [CntW-1:0]      corr_cnt_o,
    output logic [CntW-1:0]      uncorr_cnt_o,
    output logic [AW-1:0]        uncorr_add_o,
    output logic                 uncorr_pulse_o,
    output logic                 sweep_done_o,
    output scrub_state_e         scrub_state_o
);

    localparam logic [AW-1:0] LastAddr = AW'(NumWords - 1);

    scrub_state_e      state_q, state_d;
    logic [AW-1:0]     addr_q;
    logic [31:0]       ivl_q;
    logic [DW+EW-1:0]  wdata_q;
    logic [CntW-1:0]   corr_q, uncorr_q;
    logic [AW-1:0]     uncorr_add_q;
    logic              uncorr_pulse_q, sweep_done_q;

    logic [DW-1:0]     dec_data;
    logic [1:0]        dec_err;
    logic [DW+EW-1:0]  enc_code;
    logic              is_corr, is_uncorr, core_hit, advance;

    hsiao_ecc_dec #(
        .DataWidth (DW),
        .ProtWidth (EW)
    ) i_dec (
        .code (scrub_rdata_i),
        .data (dec_data),
        .err  (dec_err)
    );

    hsiao_ecc_enc #(
        .DataWidth (DW),
        .ProtWidth (EW)
    ) i_enc (
        .data (dec_data),
        .code (enc_code)
    );

    assign is_corr   = (dec_err == 2'b01);
    assign is_uncorr = dec_err[1];
    // A core write to the word under scrub carries newer data than our correction.
    assign core_hit  = core_req_i && !core_wen_i && (core_add_i == addr_q);
    assign advance   = ((state_q == CHECK) || (state_q == WRITE)) && (state_d == IDLE);

    // Next-state: wait out the interval, read, check, optionally write back.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (scrub_enable_i && (ivl_q == '0)) state_d = READ;
            READ:  if (scrub_gnt_i) state_d = CHECK;
            CHECK: state_d = (is_corr && !core_hit) ? WRITE : IDLE;
            WRITE: if (scrub_gnt_i || core_hit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Bank request outputs decoded from the current state only.
    always_comb begin
        scrub_req_o = (state_q == READ) || (state_q == WRITE);
        scrub_wen_o = (state_q == READ);
        scrub_add_o = scrub_req_o ? addr_q : '0;
    end

    // State, address walk, interval counter, writeback codeword and error statistics.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= IDLE;
            addr_q         <= '0;
            ivl_q          <= '0;
            wdata_q        <= '0;
            corr_q         <= '0;
            uncorr_q       <= '0;
            uncorr_add_q   <= '0;
            uncorr_pulse_q <= 1'b0;
            sweep_done_q   <= 1'b0;
        end else begin
            state_q <= state_d;

            if ((state_q != IDLE) && (state_d == IDLE)) begin
                ivl_q <= scrub_interval_i;
            end else if ((state_q == IDLE) && scrub_enable_i && (ivl_q != '0)) begin
                ivl_q <= ivl_q - 32'd1;
            end

            if (state_q == CHECK) wdata_q <= enc_code;

            if (advance) addr_q <= (addr_q == LastAddr) ? '0 : addr_q + 1'b1;
            sweep_done_q <= advance && (addr_q == LastAddr);

            uncorr_pulse_q <= (state_q == CHECK) && is_uncorr;
            if ((state_q == CHECK) && is_uncorr) uncorr_add_q <= addr_q;

            if (cnt_clear_i) begin
                corr_q <= '0;
            end else if ((state_q == CHECK) && is_corr && (corr_q != '1)) begin
                corr_q <= corr_q + 1'b1;
            end

            if (cnt_clear_i) begin
                uncorr_q <= '0;
            end else if ((state_q == CHECK) && is_uncorr && (uncorr_q != '1)) begin
                uncorr_q <= uncorr_q + 1'b1;
            end
        end
    end

    assign scrub_wdata_o  = wdata_q;
    assign corr_cnt_o     = corr_q;
    assign uncorr_cnt_o   = uncorr_q;
    assign uncorr_add_o   = uncorr_add_q;
    assign uncorr_pulse_o = uncorr_pulse_q;
    assign sweep_done_o   = sweep_done_q;
    assign scrub_state_o  = state_q;

endmodule

// File: doc/hci_ecc_scrubber.md
# hci_ecc_scrubber

Background ECC scrubber for one Hsiao-protected TCDM SRAM bank. It walks the bank address space at a programmable rate, reads each codeword and checks it. Single-bit errors are written back corrected; double-bit errors are counted and reported. It sits beside the bank's core-side port and always yields to core traffic; an external mux gives the bank to the scrubber only when `scrub_gnt_i` is high.

## Interface
- `DW`, 32, data bits per codeword
- `EW`, 7, Hsiao check bits per codeword ($clog2(DW)+2)
- `NumWords`, 1024, bank depth in words
- `AW`, $clog2(NumWords), word address width
- `CntW`, 16, width of the error counters
- `clk_i` in 1: clock
- `rst_ni` in 1: reset, asynchronous and active-low
- `scrub_enable_i` in 1: enables scrubbing
- `scrub_interval_i` in 32: idle cycles between words
- `core_req_i` in 1: core request to this bank this cycle
- `core_wen_i` in 1: core request is a read (1) or a write (0)
- `core_add_i` in AW: core word address
- `scrub_req_o` out 1: scrubber bank request
- `scrub_gnt_i` in 1: bank granted to scrubber (low whenever `core_req_i` is high)
- `scrub_wen_o` out 1: 1 = read, 0 = write
- `scrub_add_o` out AW: scrub word address
- `scrub_wdata_o` out DW+EW: corrected codeword, as {ecc, data}
- `scrub_rdata_i` in DW+EW: bank read codeword, as {ecc, data}
- `cnt_clear_i` in 1: synchronous clear of the counters
- `corr_cnt_o` out CntW: corrected (single-bit) errors, saturating
- `uncorr_cnt_o` out CntW: uncorrectable errors, saturating
- `uncorr_add_o` out AW: address of the last uncorrectable error
- `uncorr_pulse_o` out 1: one-cycle pulse per uncorrectable error
- `sweep_done_o` out 1: one-cycle pulse when the address wraps

## Operation
- FSM states, in `hci_package::scrub_state_e`: IDLE, READ, CHECK, WRITE.
- IDLE:
  - On entry, the down-counter loads `scrub_interval_i`.
  - The counter decrements each cycle while `scrub_enable_i` is high and holds while it is low.
  - When the counter is 0 and `scrub_enable_i` is high, go to READ. An interval of 0 gives back-to-back words.
- READ:
  - Drives `scrub_req_o`=1, `scrub_wen_o`=1, `scrub_add_o`=addr.
  - Holds until `scrub_gnt_i`, then goes to CHECK.
- CHECK:
  - `scrub_rdata_i` is valid this cycle.
  - `hsiao_ecc_dec` gives err[1:0]. `hsiao_ecc_enc` re-encodes the corrected data into a register.
  - err=00: advance.
  - err=01: increment `corr_cnt`, go to WRITE.
  - err=10 or 11: increment `uncorr_cnt`, latch `uncorr_add_o`=addr, pulse `uncorr_pulse_o`, advance. No writeback.
- WRITE:
  - Drives `scrub_req_o`=1, `scrub_wen_o`=0, `scrub_wdata_o`=registered codeword.
  - Holds until `scrub_gnt_i`, then advances.
- Hazard: a core write (`core_req_i` & !`core_wen_i`) to `core_add_i`==addr in CHECK or WRITE, before the write is granted, cancels the writeback. The FSM advances without writing. Core data is newer and must not be overwritten.
- Advance:
  - addr increments. At NumWords-1 it wraps to 0 and `sweep_done_o` pulses.
  - The FSM returns to IDLE.
- Enable deasserted mid-word: the current word completes (through WRITE if pending), then the FSM parks in IDLE. addr is retained.
- Counters:
  - Saturate at 2^CntW-1.
  - `cnt_clear_i` wins over a same-cycle increment; the result is 0.

## Timing
- Reset values:
  - state IDLE, addr 0, interval counter 0.
  - All outputs 0: `scrub_req_o`, `scrub_wen_o`, `scrub_add_o`, `scrub_wdata_o`, both counters, `uncorr_add_o`, both pulses.
- SRAM read latency is 1: rdata arrives the cycle after the read grant.
- Clean-word latency: READ(1 with gnt) + CHECK(1) = 2 cycles, then IDLE.
- Corrected-word latency: 3 cycles with an immediate grant.
- `scrub_req_o` and the address/data outputs are stable while waiting for grant. The requester never drops the request before grant.
- The decoder is combinational inside CHECK. The write codeword is registered, so no path exists from `scrub_rdata_i` to the outputs.
- Pulses are high for exactly one cycle, registered.
- Asynchronous reset mid-word aborts immediately. No partial write is issued after reset.

## Structure
- `hci_package` holds `scrub_state_e` and a `HSIAO_EW(dw)` width function.
- Reused sub-modules: `hsiao_ecc_dec` and `hsiao_ecc_enc` (DataWidth=DW, ProtWidth=EW). No new sub-module.
- Single always_ff for the FSM, address, counter and stats; separate always_comb for next-state.

## Test plan
- Interval=3, enable, clean memory:
  - Reads at addr 0,1,2 are spaced 6 cycles apart (4 IDLE + READ + CHECK).
  - No writes; counters stay 0.
- Flip data bit 5 at addr 7:
  - Exactly one write to 7 with the original codeword.
  - `corr_cnt_o`=1.
  - A reread returns a clean word.
- Flip 2 bits at addr 9:
  - No write.
  - `uncorr_cnt_o`=1, `uncorr_add_o`=9, one `uncorr_pulse_o`.
- Single error at addr 4, core write to 4 while the scrubber waits in WRITE with `scrub_gnt_i`=0:
  - Writeback is dropped; memory holds the core data.
  - `corr_cnt_o`=1.
- NumWords=8, interval=0:
  - `sweep_done_o` pulses once every 8 words; addr wraps 7 -> 0.
- Counter at 2^CntW-1 plus a new error: the counter holds.
- `cnt_clear_i` in the same cycle as an increment: the counter becomes 0.
- Deassert `rst_ni` mid-READ: outputs are 0 immediately and addr restarts at 0.
